// File: rtl/bit_scan_unit.sv
// rtl/bit_scan_unit.sv - multi-cycle popcount / leading / trailing zero-one counter
module bit_scan_unit #(
    parameter int  WIDTH = 32,
    parameter int  CHUNK = 4,
    localparam int RW    = $clog2(WIDTH + 1),
    localparam int NCH   = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    result
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] OP_POPC = 3'd0;
    localparam logic [2:0] OP_CLZ  = 3'd1;
    localparam logic [2:0] OP_CLO  = 3'd2;
    localparam logic [2:0] OP_CTO  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [2:0]       opr;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_init;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    acc_next;
    logic [RW-1:0]    cnt_pop;
    logic [RW-1:0]    lowest;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] cur;
    logic             last;
    logic             term;

    // Leading-count modes scan a reversed word; ones-count modes scan an inverted one,
    // so the RUN datapath only ever looks for the lowest set bit from bit 0 upward.
    always_comb begin
        work_init = a;
        if (op == OP_CLZ || op == OP_CLO) begin
            for (int i = 0; i < WIDTH; i++) begin
                work_init[i] = a[WIDTH-1-i];
            end
        end
        if (op == OP_CLO || op == OP_CTO) begin
            work_init = ~work_init;
        end
    end

    assign cur  = work[CHUNK-1:0];
    assign last = (idx == IW'(NCH - 1));

    always_comb begin
        cnt_pop = '0;
        lowest  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt_pop = cnt_pop + RW'(cur[i]);
        end
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (cur[i]) begin
                lowest = RW'(i);
            end
        end
    end

    always_comb begin
        acc_next = acc;
        term     = 1'b0;
        if (opr == OP_POPC) begin
            acc_next = acc + cnt_pop;
            term     = last;
        end else if (opr > OP_CTO) begin
            acc_next = '0;
            term     = 1'b1;
        end else if (cur == '0) begin
            acc_next = acc + RW'(CHUNK);
            term     = last;
        end else begin
            acc_next = acc + lowest;
            term     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            work   <= '0;
            idx    <= '0;
            opr    <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    acc <= acc_next;
                    if (term) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next;
                    end else begin
                        idx  <= idx + 1'b1;
                        work <= work >> CHUNK;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        work  <= work_init;
                        acc   <= '0;
                        idx   <= '0;
                        opr   <= op;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scan_unit.sv
// tb/tb_bit_scan_unit.sv - randomized bench for bit_scan_unit at three geometries
module tb_bit_scan_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op_s;
    logic [63:0] av[3];

    logic       busy16, done16, busy32, done32, busy64, done64;
    logic [4:0] res16;
    logic [5:0] res32;
    logic [6:0] res64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bit_scan_unit #(.WIDTH(16), .CHUNK(1)) u16 (
        .clk(clk), .reset(reset), .start(start), .op(op_s), .a(av[0][15:0]),
        .busy(busy16), .done(done16), .result(res16)
    );
    bit_scan_unit u32 (
        .clk(clk), .reset(reset), .start(start), .op(op_s), .a(av[1][31:0]),
        .busy(busy32), .done(done32), .result(res32)
    );
    bit_scan_unit #(.WIDTH(64), .CHUNK(8)) u64 (
        .clk(clk), .reset(reset), .start(start), .op(op_s), .a(av[2]),
        .busy(busy64), .done(done64), .result(res64)
    );

    function automatic int wof(int i);
        return (i == 0) ? 16 : (i == 1) ? 32 : 64;
    endfunction

    function automatic int cof(int i);
        return (i == 0) ? 1 : (i == 1) ? 4 : 8;
    endfunction

    function automatic int ref_result(int w, logic [2:0] o, logic [63:0] v);
        int r = 0;
        case (o)
            3'd0: for (int i = 0; i < w; i++) r += int'(v[i]);
            3'd1: for (int i = w - 1; i >= 0 && !v[i]; i--) r++;
            3'd2: for (int i = w - 1; i >= 0 && v[i]; i--) r++;
            3'd3: for (int i = 0; i < w && !v[i]; i++) r++;
            3'd4: for (int i = 0; i < w && v[i]; i++) r++;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic int ref_k(int w, int c, logic [2:0] o, int r);
        if (o == 3'd0) return w / c;
        if (o > 3'd4) return 1;
        return (r == w) ? w / c : r / c + 1;
    endfunction

    function automatic logic [63:0] gen(int w, logic [2:0] o);
        logic [63:0] v, m;
        int sh;
        v  = {$urandom, $urandom};
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        sh = $urandom_range(0, w);
        case (o)
            3'd1: v = (v & m) >> sh;
            3'd2: v = ~((~v & m) >> sh) & m;
            3'd3: v = v << sh;
            3'd4: v = ~((~v) << sh);
            default: v = v;
        endcase
        return v & m;
    endfunction

    // Transaction-level reference: per geometry, latency and result from the counting rules.
    logic m_busy[3], m_done[3];
    int   m_res[3], m_rem[3], m_pend[3];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
                m_res[i] <= 0; m_rem[i] <= 0; m_pend[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_busy[i]) begin
                    if (m_rem[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_res[i]  <= m_pend[i];
                    end
                    m_rem[i] <= m_rem[i] - 1;
                end else begin
                    m_done[i] <= 1'b0;
                    if (start) begin
                        m_busy[i] <= 1'b1;
                        m_pend[i] <= ref_result(wof(i), op_s, av[i]);
                        m_rem[i]  <= ref_k(wof(i), cof(i), op_s,
                                           ref_result(wof(i), op_s, av[i]));
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input int i, input logic b, input logic d, input int r);
        tests++;
        if (b !== m_busy[i] || d !== m_done[i] || r != m_res[i]) begin
            fails++;
            $display("FAIL out_w%0d t=%0t: busy/done/result got %b/%b/%0d expected %b/%b/%0d",
                     wof(i), $time, b, d, r, m_busy[i], m_done[i], m_res[i]);
        end
    endtask

    always @(negedge clk) begin
        chk_out(0, busy16, done16, int'(res16));
        chk_out(1, busy32, done32, int'(res32));
        chk_out(2, busy64, done64, int'(res64));
    end

    task automatic run32(input logic [2:0] o, input logic [31:0] v, input int exp_r,
                         input int exp_k, input bit disturb, input string name);
        int n = 0;
        while (busy32 && n < 200) begin @(posedge clk); #2; n++; end
        op_s = o; av[1] = {32'd0, v}; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        if (disturb) begin
            op_s = 3'd0; av[1] = {32'd0, $urandom}; start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0; n = 1;
        end
        while (!done32 && n < 200) begin @(posedge clk); #2; n++; end
        chk({name, "_result"}, int'(res32), exp_r);
        chk({name, "_latency"}, n, exp_k);
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b0; start = 1'b0; op_s = 3'd0;
        for (int i = 0; i < 3; i++) av[i] = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy", int'(busy32), 0);
        chk("reset_done", int'(done32), 0);
        chk("reset_result", int'(res32), 0);
        reset = 1'b1;
        @(posedge clk); #2;

        run32(3'd0, 32'hF0F0_000F, 12, 8, 1'b0, "popc");
        run32(3'd1, 32'h0001_0000, 15, 4, 1'b0, "clz_bit16");
        run32(3'd1, 32'h0000_0000, 32, 8, 1'b0, "clz_zero");
        run32(3'd1, 32'h8000_0000, 0, 1, 1'b0, "clz_msb");
        run32(3'd4, 32'h0000_00FF, 8, 3, 1'b0, "cto_ff");
        run32(3'd3, 32'h0000_0100, 8, 3, 1'b0, "ctz_100");
        run32(3'd6, 32'h1234_5678, 0, 1, 1'b0, "invalid_op");
        run32(3'd1, 32'h0001_0000, 15, 4, 1'b1, "start_while_busy");

        // Start held through DONE: the next operation is accepted with no idle cycle.
        while (busy32) begin @(posedge clk); #2; end
        op_s = 3'd3; av[1] = 64'h100; start = 1'b1;
        @(posedge clk); #2;
        n = 0;
        while (!done32 && n < 200) begin @(posedge clk); #2; n++; end
        chk("b2b_first_latency", n, 3);
        chk("b2b_first_result", int'(res32), 8);
        op_s = 3'd1; av[1] = 64'h8000_0000;
        @(posedge clk); #2;
        start = 1'b0;
        chk("b2b_busy_no_idle", int'(busy32), 1);
        @(posedge clk); #2;
        chk("b2b_second_done", int'(done32), 1);
        chk("b2b_second_result", int'(res32), 0);

        run32(3'd2, 32'hFFFF_FFFF, 32, 8, 1'b0, "clo_ones");

        // Reset in the third RUN cycle of a POPC.
        op_s = 3'd0; av[1] = 64'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrun_reset_busy", int'(busy32), 0);
        chk("midrun_reset_done", int'(done32), 0);
        chk("midrun_reset_result", int'(res32), 0);
        #4 reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #2; if (done32) seen = 1'b1; end
        chk("no_done_after_reset", int'(seen), 0);
        run32(3'd3, 32'h0000_0001, 0, 1, 1'b0, "ctz_after_reset");

        for (int o = 0; o < 8; o++) begin
            int cnt = (o == 1 || o == 4) ? 1000 : 100;
            for (int t = 0; t < cnt; t++) begin
                n = 0;
                while ((m_busy[0] || m_busy[1] || m_busy[2]) && n < 200) begin
                    @(posedge clk); #2; n++;
                end
                if (n >= 200) chk("random_idle_timeout", n, 0);
                op_s = 3'(o);
                for (int i = 0; i < 3; i++) av[i] = gen(wof(i), 3'(o));
                start = 1'b1;
                @(posedge clk); #2;
                start = 1'b0;
            end
        end
        repeat (20) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
